stop_go_keystream_gen: RTL
==========================

# stop_go_keystream_gen

Parametrised stop-and-go keystream generator built from three LFSRs of configurable width. It supports two selectable modes:
- Beth-Piper stop-and-go.
- Alternating-step.

It uses clock enables rather than a gated clock, loads seeds at runtime, runs an optional warm-up phase, and delivers keystream words over a valid/ready handshake. It feeds keystream words to the Vigenère cipher datapath.

## Interface
- WIDTH, 32: LFSR and keystream word width; legal range 8..64.
- TAPS1 / TAPS2 / TAPS3, package defaults: feedback tap masks (WIDTH bits, bit i set means state bit i is XORed into feedback).
- SEED1 / SEED2 / SEED3, package defaults: reset seeds; also the substitute value for any all-zero loaded seed. Must be nonzero.
- WARMUP, 64: number of discarded steps after reset or load; legal range 1..1023.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- seed_load  in  1  single-cycle request to load seeds and mode.
- seed_data  in  3*WIDTH  {seed3, seed2, seed1}; seed1 is in the LSBs.
- mode  in  1  0 = Beth-Piper stop-and-go, 1 = alternating-step; sampled only on seed_load.
- ks_ready  in  1  consumer accepts ks_data.
- ks_valid  out  1  ks_data is a valid keystream word.
- ks_data  out  WIDTH  lf2 ^ lf3 (current register state).
- busy  out  1  high during WARMUP.

## Operation
- Step function for each LFSR (Fibonacci): next = {s[WIDTH-2:0], ^(s & TAPS)}.
- Control bit c is lf1[WIDTH-1] of the current state.
- Stepping in mode 0: lf1 and lf3 always step; lf2 steps only when c = 1.
- Stepping in mode 1: lf1 always steps; lf2 steps when c = 1, lf3 steps when c = 0.
- FSM has two states, WARMUP and RUN.
- WARMUP:
  - The LFSRs step every cycle and the counter increments.
  - When the counter reaches WARMUP-1 and the step is taken, the FSM goes to RUN.
  - ks_valid = 0 and busy = 1.
- RUN:
  - ks_valid = 1 and busy = 0.
  - LFSRs step only on the cycle where ks_valid & ks_ready is true; otherwise all state holds and ks_data is stable.
- seed_load:
  - Accepted in any state, at the next edge.
  - Loads lf1/lf2/lf3 from seed_data, registers mode into mode_q, clears the counter, and enters WARMUP.
  - ks_valid falls at that same edge.
- Zero seeds: any all-zero seed field is replaced by the corresponding SEEDn, so an LFSR can never lock at zero.
- Simultaneous seed_load with ks_valid & ks_ready: the word is counted as consumed by the consumer. The load takes priority and no step is applied.
- Reset mid-operation: all state returns to its reset values immediately (asynchronous assertion). Release is used synchronously.

## Timing
- Reset values:
  - lf1/lf2/lf3 = SEED1/SEED2/SEED3; mode_q = 0; counter = 0.
  - ks_valid = 0; ks_data = SEED2 ^ SEED3.
  - busy = 1 and state = WARMUP when SNG_WARMUP_EN is defined; otherwise busy = 0 and state = RUN.
- After reset release or seed_load, ks_valid rises after exactly WARMUP rising edges (first word on edge WARMUP).
- Throughput: one word per cycle while ks_ready = 1. There is no combinational path from ks_ready to ks_valid.
- ks_data changes only on an accepted handshake, a seed_load, or warm-up steps.

## Configuration
- SNG_WARMUP_EN defined:
  - WARMUP state, counter and busy are compiled in, with behaviour as described above.
- SNG_WARMUP_EN undefined:
  - WARMUP state, counter and busy are removed, and the WARMUP parameter is ignored.
  - busy is tied to 0; the FSM is always in RUN.
  - ks_valid goes to 1 one edge after reset release and one edge after seed_load.
  - The first word is the seed-derived value (seed2 ^ seed3).

## Structure
- Package stop_go_pkg holds:
  - Default TAPS/SEED constants for WIDTH = 32.
  - The mode enum (SNG_BETH_PIPER, SNG_ALT_STEP).
  - The state enum (SNG_WARMUP, SNG_RUN).
- Sub-module sng_lfsr, instantiated three times, with parameters WIDTH, TAPS and SEED and inputs clk, rst, en, load and load_val. It contains the zero-seed substitution.
- The top level contains the FSM, counter, step-enable decode and handshake.

## Test plan
- Reset with SNG_WARMUP_EN, WARMUP = 64, ks_ready = 1: busy = 1 for 64 edges, ks_valid rises on edge 64, and the following 1000 ks_data words match the golden C model.
- Stall: ks_ready = 0 for 10 cycles in RUN gives ks_data constant and ks_valid = 1. Releasing the stall gives the next model word.
- Mode 0 stop behaviour, macro off, seed1 = 32'h0000_0001, TAPS1 = default: for the first 31 accepted words, ks_data ^ lf3_model equals seed2 (lf2 held).
- Mode 1 with the same seeds: lf2 is held and lf3 steps for the first 31 words. The sequence matches the model.
- seed_load with seed_data = 0: lf1/lf2/lf3 = SEED1/2/3, and the output sequence is identical to the post-reset sequence.
- seed_load asserted in the same cycle as an accepted handshake: ks_valid = 0 next cycle, then WARMUP, then the new-seed sequence. rst asserted mid-RUN clears ks_valid asynchronously.

Source files
------------

// File: rtl/stop_go_pkg.sv
// -----------------------------------------------------------------------------
// stop_go_pkg
// Shared definitions for the stop-and-go keystream generator:
//   - default feedback tap masks and reset seeds for a 32-bit build
//   - mode enum (Beth-Piper stop-and-go / alternating-step)
//   - FSM state enum (warm-up / run)
//   - step-enable decode helper used by the top level
// -----------------------------------------------------------------------------
package stop_go_pkg;

    // Tap masks: bit i set means state bit i feeds the XOR.
    // Each mask corresponds to a primitive degree-32 polynomial.
    localparam logic [31:0] SNG_TAPS1 = 32'h8020_0003;  // x^32+x^22+x^2+x+1
    localparam logic [31:0] SNG_TAPS2 = 32'hA300_0000;  // x^32+x^30+x^26+x^25+1
    localparam logic [31:0] SNG_TAPS3 = 32'hE000_0200;  // x^32+x^31+x^30+x^10+1

    // Reset seeds; also substituted for any all-zero loaded seed.
    localparam logic [31:0] SNG_SEED1 = 32'h9E37_79B9;
    localparam logic [31:0] SNG_SEED2 = 32'h7F4A_7C15;
    localparam logic [31:0] SNG_SEED3 = 32'hC2B2_AE35;

    typedef enum logic {
        SNG_BETH_PIPER = 1'b0,
        SNG_ALT_STEP   = 1'b1
    } sng_mode_e;

    typedef enum logic {
        SNG_WARMUP = 1'b0,
        SNG_RUN    = 1'b1
    } sng_state_e;

    // Per-LFSR step enables {lf3, lf2, lf1} for a global step request.
    // lf1 always steps; lf2 follows the control bit in both modes;
    // lf3 steps unconditionally in Beth-Piper, on ~ctrl in alternating-step.
    function automatic logic [2:0] sng_step_enables(input logic      step,
                                                    input logic      ctrl,
                                                    input sng_mode_e mode);
        logic [2:0] en;
        en[0] = step;
        en[1] = step & ctrl;
        en[2] = step & ((mode == SNG_BETH_PIPER) | ~ctrl);
        return en;
    endfunction

endpackage

// File: rtl/sng_lfsr.sv
// -----------------------------------------------------------------------------
// sng_lfsr
// One Fibonacci LFSR with clock enable and parallel load.
//   next = {s[WIDTH-2:0], ^(s & TAPS)}
// A load of all zeros is replaced by SEED so the register can never lock up.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset (state <= SEED)
//   en       in   advance one step this cycle
//   load     in   load load_val (has priority over en)
//   load_val in   WIDTH-bit value to load
//   o_state  out  current register state
// -----------------------------------------------------------------------------
module sng_lfsr #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_next;

    assign w_load_val = (load_val == '0) ? SEED : load_val;
    assign w_next     = {r_state[WIDTH-2:0], ^(r_state & TAPS)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= w_load_val;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/stop_go_keystream_gen.sv
// -----------------------------------------------------------------------------
// stop_go_keystream_gen
// Three-LFSR stop-and-go keystream generator (Beth-Piper or alternating-step)
// delivering WIDTH-bit words over a valid/ready handshake.
// Optional feature macro: SNG_WARMUP_EN
//   defined   -> WARMUP discarded steps after reset/load, busy high meanwhile
//   undefined -> no warm-up; ks_valid rises one edge after reset/load and the
//                first word is seed2 ^ seed3
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   seed_load  in   load {seed3,seed2,seed1} and mode at the next edge
//   seed_data  in   3*WIDTH seeds, seed1 in the LSBs
//   mode       in   0 = Beth-Piper, 1 = alternating-step (sampled on seed_load)
//   ks_ready   in   consumer accepts ks_data
//   ks_valid   out  ks_data holds a valid keystream word
//   ks_data    out  lf2 ^ lf3
//   busy       out  warm-up in progress
// -----------------------------------------------------------------------------
module stop_go_keystream_gen
    import stop_go_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] TAPS1  = WIDTH'(SNG_TAPS1),
    parameter logic [WIDTH-1:0] TAPS2  = WIDTH'(SNG_TAPS2),
    parameter logic [WIDTH-1:0] TAPS3  = WIDTH'(SNG_TAPS3),
    parameter logic [WIDTH-1:0] SEED1  = WIDTH'(SNG_SEED1),
    parameter logic [WIDTH-1:0] SEED2  = WIDTH'(SNG_SEED2),
    parameter logic [WIDTH-1:0] SEED3  = WIDTH'(SNG_SEED3),
    parameter int               WARMUP = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_load,
    input  logic [3*WIDTH-1:0] seed_data,
    input  logic               mode,
    input  logic               ks_ready,
    output logic               ks_valid,
    output logic [WIDTH-1:0]   ks_data,
    output logic               busy
);

    // Elaboration-time legality checks on the configuration.
    if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("stop_go_keystream_gen: WIDTH must be in 8..64");
    end
    if (WARMUP < 1 || WARMUP > 1023) begin : g_bad_warmup
        $error("stop_go_keystream_gen: WARMUP must be in 1..1023");
    end

    localparam logic [3*WIDTH-1:0] TAPS_ALL = {TAPS3, TAPS2, TAPS1};
    localparam logic [3*WIDTH-1:0] SEED_ALL = {SEED3, SEED2, SEED1};

    logic [2:0][WIDTH-1:0] w_lf;
    logic [2:0]            w_en;
    logic                  w_ctrl;
    logic                  w_fire;
    logic                  w_step;
    logic                  w_unused_lf1;
    logic                  r_valid;
    sng_mode_e             r_mode;

    for (genvar gi = 0; gi < 3; gi++) begin : g_lfsr
        sng_lfsr #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS_ALL[gi*WIDTH +: WIDTH]),
            .SEED  (SEED_ALL[gi*WIDTH +: WIDTH])
        ) u_lfsr (
            .clk      (clk),
            .rst      (rst),
            .en       (w_en[gi]),
            .load     (seed_load),
            .load_val (seed_data[gi*WIDTH +: WIDTH]),
            .o_state  (w_lf[gi])
        );
    end

    // Only the MSB of lf1 drives the control path.
    assign w_unused_lf1 = ^w_lf[0][WIDTH-2:0];
    assign w_ctrl       = w_lf[0][WIDTH-1];
    assign w_fire       = r_valid & ks_ready;
    assign w_en         = sng_step_enables(w_step, w_ctrl, r_mode);

`ifdef SNG_WARMUP_EN
    localparam int               CNT_W = 10;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WARMUP - 1);

    sng_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;

    // A load wins over any step, including a handshake in the same cycle.
    assign w_step = ~seed_load & ((r_state == SNG_WARMUP) | w_fire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SNG_WARMUP;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_mode  <= SNG_BETH_PIPER;
        end else if (seed_load) begin
            r_state <= SNG_WARMUP;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_mode  <= sng_mode_e'(mode);
        end else begin
            case (r_state)
                SNG_WARMUP: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Last discarded step: next state's output is the first word.
                    if (r_cnt == LAST) begin
                        r_state <= SNG_RUN;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_valid <= 1'b1;
                end
            endcase
        end
    end

    assign busy = (r_state == SNG_WARMUP);
`else
    assign w_step = ~seed_load & w_fire;

    // Always in RUN: valid drops only for the edge of a load or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_mode  <= SNG_BETH_PIPER;
        end else if (seed_load) begin
            r_valid <= 1'b0;
            r_mode  <= sng_mode_e'(mode);
        end else begin
            r_valid <= 1'b1;
        end
    end

    assign busy = 1'b0;
`endif

    assign ks_valid = r_valid;
    assign ks_data  = w_lf[1] ^ w_lf[2];

endmodule
